// File: rtl/atomic_counter_bank.sv
// Bank of NUM_CH wide event counters with wrap/saturate modes, sticky overflow
// flags and snapshot-consistent multi-word reads over a narrow read bus.
module atomic_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int DATABUS   = 32,
  parameter int COUNTLEN  = 64,
  parameter int FAST_STEP = 1000000,
  parameter int SATURATE  = 0,
  localparam int NWORDS   = COUNTLEN / DATABUS,
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WW       = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   trig_i,
  input  logic [NUM_CH-1:0]   fast_i,
  input  logic                req_i,
  input  logic [CHW-1:0]      ch_i,
  input  logic [WW-1:0]       word_i,
  input  logic                atomic_i,
  output logic                ack_o,
  output logic [DATABUS-1:0]  data_o,
  output logic                err_o,
  output logic [NUM_CH-1:0]   ovf_o
);

  localparam logic [COUNTLEN:0]   STEP_FAST = (COUNTLEN+1)'(FAST_STEP);
  localparam logic [COUNTLEN:0]   STEP_ONE  = {{COUNTLEN{1'b0}}, 1'b1};
  localparam logic [COUNTLEN:0]   STEP_NONE = {(COUNTLEN+1){1'b0}};
  localparam logic [COUNTLEN-1:0] ALL_ONES  = {COUNTLEN{1'b1}};
  localparam logic [COUNTLEN-1:0] CNT_ZERO  = {COUNTLEN{1'b0}};
  localparam logic [DATABUS-1:0]  DATA_ZERO = {DATABUS{1'b0}};

  logic [COUNTLEN-1:0] r_cnt [NUM_CH];
  logic [NUM_CH-1:0]   r_ovf;
  logic [COUNTLEN-1:0] r_snap;
  logic [CHW-1:0]      r_snap_ch;
  logic                r_snap_vld;
  logic                r_ack;
  logic                r_err;
  logic [DATABUS-1:0]  r_data;

  logic [COUNTLEN:0]   w_sum  [NUM_CH];
  logic [COUNTLEN-1:0] w_next [NUM_CH];
  logic [NUM_CH-1:0]   w_ovf_set;

  logic                w_ch_ok;
  logic                w_word_ok;
  logic                w_word_zero;
  logic                w_atom_bad;
  logic                w_err;
  logic                w_cap;
  logic [COUNTLEN-1:0] w_sel_cnt;
  logic [COUNTLEN-1:0] w_src;
  logic [DATABUS-1:0]  w_rd_word;

  // Next count per channel; the sum is one bit wider so the carry marks overflow
  always_comb begin
    w_ovf_set = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum[c]  = {1'b0, r_cnt[c]} +
                  (trig_i[c] ? (fast_i[c] ? STEP_FAST : STEP_ONE) : STEP_NONE);
      w_next[c] = w_sum[c][COUNTLEN-1:0];
      if (SATURATE != 0) begin
        if (trig_i[c] && (r_cnt[c] == ALL_ONES)) begin
          w_next[c]    = ALL_ONES;
          w_ovf_set[c] = 1'b1;
        end else if (w_sum[c][COUNTLEN]) begin
          w_next[c]    = ALL_ONES;
          w_ovf_set[c] = 1'b1;
        end else begin
          w_next[c]    = w_sum[c][COUNTLEN-1:0];
        end
      end else begin
        w_ovf_set[c] = w_sum[c][COUNTLEN];
      end
    end
  end

  // Request decode and read-word selection from pre-update register values
  always_comb begin
    w_ch_ok     = (32'(ch_i) < 32'(NUM_CH));
    w_word_ok   = (32'(word_i) < 32'(NWORDS));
    w_word_zero = (word_i == {WW{1'b0}});
    w_atom_bad  = atomic_i && !w_word_zero && (!r_snap_vld || (ch_i != r_snap_ch));
    w_err       = !w_ch_ok || !w_word_ok || w_atom_bad;
    w_cap       = req_i && atomic_i && w_word_zero && !w_err;

    w_sel_cnt = CNT_ZERO;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel_cnt = (ch_i == CHW'(c)) ? r_cnt[c] : w_sel_cnt;
    end

    // Atomic reads of upper words come from the snapshot, everything else is live
    w_src = (atomic_i && !w_word_zero) ? r_snap : w_sel_cnt;

    w_rd_word = DATA_ZERO;
    for (int w = 0; w < NWORDS; w++) begin
      w_rd_word = (word_i == WW'(w)) ? w_src[w*DATABUS +: DATABUS] : w_rd_word;
    end
  end

  // Counter state and sticky overflow flags; a same-edge overflow beats the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= CNT_ZERO;
      end
      r_ovf <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= w_next[c];
        if (w_ovf_set[c]) begin
          r_ovf[c] <= 1'b1;
        end else if (w_cap && (ch_i == CHW'(c))) begin
          r_ovf[c] <= 1'b0;
        end else begin
          r_ovf[c] <= r_ovf[c];
        end
      end
    end
  end

  // Snapshot capture on a valid atomic word-0 read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap     <= CNT_ZERO;
      r_snap_ch  <= {CHW{1'b0}};
      r_snap_vld <= 1'b0;
    end else if (w_cap) begin
      r_snap     <= w_sel_cnt;
      r_snap_ch  <= ch_i;
      r_snap_vld <= 1'b1;
    end else begin
      r_snap     <= r_snap;
      r_snap_ch  <= r_snap_ch;
      r_snap_vld <= r_snap_vld;
    end
  end

  // One-cycle response stage; data is forced to zero unless a valid ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_data <= DATA_ZERO;
    end else begin
      r_ack  <= req_i;
      r_err  <= req_i && w_err;
      r_data <= (req_i && !w_err) ? w_rd_word : DATA_ZERO;
    end
  end

  assign ack_o  = r_ack;
  assign err_o  = r_err;
  assign data_o = r_data;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Directed plus random bench for atomic_counter_bank: three configurations
// (64-bit wrap, 24-bit wrap, 24-bit saturate) checked against one arithmetic model.
module tb_atomic_counter_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] trig_i, fast_i;
  logic       req_i, atomic_i;
  logic [2:0] ch_i;
  logic       word_m;
  logic [1:0] word_s;

  logic        ack0, ack1, ack2, err0, err1, err2;
  logic [31:0] data0;
  logic [7:0]  data1, data2;
  logic [4:0]  ovf0, ovf1, ovf2;

  logic        ack_w [3];
  logic        err_w [3];
  logic [31:0] data_w [3];
  logic [4:0]  ovf_w [3];

  assign ack_w[0] = ack0;  assign ack_w[1] = ack1;  assign ack_w[2] = ack2;
  assign err_w[0] = err0;  assign err_w[1] = err1;  assign err_w[2] = err2;
  assign data_w[0] = data0;
  assign data_w[1] = {24'd0, data1};
  assign data_w[2] = {24'd0, data2};
  assign ovf_w[0] = ovf0;  assign ovf_w[1] = ovf1;  assign ovf_w[2] = ovf2;

  always #5 clk = ~clk;

  atomic_counter_bank #(.NUM_CH(5)) u_main (
    .clk(clk), .reset(reset), .trig_i(trig_i), .fast_i(fast_i), .req_i(req_i),
    .ch_i(ch_i), .word_i(word_m), .atomic_i(atomic_i),
    .ack_o(ack0), .data_o(data0), .err_o(err0), .ovf_o(ovf0));

  atomic_counter_bank #(.NUM_CH(5), .DATABUS(8), .COUNTLEN(24), .FAST_STEP(4096),
                        .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .trig_i(trig_i), .fast_i(fast_i), .req_i(req_i),
    .ch_i(ch_i), .word_i(word_s), .atomic_i(atomic_i),
    .ack_o(ack1), .data_o(data1), .err_o(err1), .ovf_o(ovf1));

  atomic_counter_bank #(.NUM_CH(5), .DATABUS(8), .COUNTLEN(24), .FAST_STEP(4096),
                        .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .trig_i(trig_i), .fast_i(fast_i), .req_i(req_i),
    .ch_i(ch_i), .word_i(word_s), .atomic_i(atomic_i),
    .ack_o(ack2), .data_o(data2), .err_o(err2), .ovf_o(ovf2));

  // Configuration of each DUT as seen by the model
  int          cfg_len  [3] = '{64, 24, 24};
  int          cfg_db   [3] = '{32, 8, 8};
  int          cfg_nw   [3] = '{2, 3, 3};
  longint      cfg_fast [3] = '{1000000, 4096, 4096};
  bit          cfg_sat  [3] = '{1'b0, 1'b0, 1'b1};

  logic [63:0] m_cnt  [3][5];
  logic [63:0] m_snap [3];
  int          m_sch  [3];
  bit          m_svld [3];
  bit   [4:0]  m_ovf  [3];
  bit          e_ack;
  bit          e_err  [3];
  logic [31:0] e_data [3];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 5; c++) m_cnt[k][c] = 64'd0;
      m_snap[k] = 64'd0; m_sch[k] = 0; m_svld[k] = 1'b0; m_ovf[k] = 5'd0;
      e_err[k] = 1'b0; e_data[k] = 32'd0;
    end
    e_ack = 1'b0;
  endtask

  // One clock edge of the behavioural model: response from pre-edge state, then update
  task automatic model_step(input logic [4:0] t, input logic [4:0] f, input bit rq,
                            input int ch, input int wm, input int ws, input bit at);
    logic [63:0] src;
    logic [64:0] sum, maxv, mask;
    int  w;
    bit  bad, cap;
    e_ack = rq;
    for (int k = 0; k < 3; k++) begin
      w    = (k == 0) ? wm : ws;
      bad  = (ch >= 5) || (w >= cfg_nw[k]) || (at && w > 0 && (!m_svld[k] || ch != m_sch[k]));
      cap  = rq && !bad && at && (w == 0);
      maxv = (65'd1 << cfg_len[k]) - 65'd1;
      mask = (65'd1 << cfg_db[k]) - 65'd1;
      e_err[k]  = rq && bad;
      e_data[k] = 32'd0;
      if (rq && !bad) begin
        src = (at && w > 0) ? m_snap[k] : m_cnt[k][ch];
        e_data[k] = 32'(({1'b0, src} >> (w * cfg_db[k])) & mask);
      end
      if (cap) begin
        m_snap[k] = m_cnt[k][ch]; m_sch[k] = ch; m_svld[k] = 1'b1; m_ovf[k][ch] = 1'b0;
      end
      for (int c = 0; c < 5; c++) begin
        if (t[c]) begin
          sum = {1'b0, m_cnt[k][c]} + (f[c] ? 65'(cfg_fast[k]) : 65'd1);
          if (sum > maxv) begin
            m_ovf[k][c] = 1'b1;
            m_cnt[k][c] = cfg_sat[k] ? maxv[63:0] : 64'(sum - maxv - 65'd1);
          end else begin
            m_cnt[k][c] = sum[63:0];
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk("ack",  k, 64'(ack_w[k]),  64'(e_ack));
      chk("err",  k, 64'(err_w[k]),  64'(e_err[k]));
      chk("data", k, 64'(data_w[k]), 64'(e_data[k]));
      chk("ovf",  k, 64'(ovf_w[k]),  64'(m_ovf[k]));
    end
  endtask

  task automatic cycle(input logic [4:0] t, input logic [4:0] f, input bit rq,
                       input int ch, input int wm, input int ws, input bit at);
    trig_i = t; fast_i = f; req_i = rq; ch_i = 3'(ch);
    word_m = 1'(wm); word_s = 2'(ws); atomic_i = at;
    @(posedge clk);
    model_step(t, f, rq, ch, wm, ws, at);
    #1;
    compare_all();
  endtask

  initial begin
    logic [4:0] rt, rf;
    int rch, last_ch;
    reset = 1'b0;
    trig_i = 5'd0; fast_i = 5'd0; req_i = 1'b0; ch_i = 3'd0;
    word_m = 1'b0; word_s = 2'd0; atomic_i = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    compare_all();
    #3 reset = 1'b1;

    // Error paths right after reset
    cycle(5'd0, 5'd0, 1'b1, 0, 1, 1, 1'b1);
    chk("t4_atomic_w1_after_reset", 0, 64'(err_w[0]), 64'd1);
    cycle(5'd0, 5'd0, 1'b1, 5, 0, 0, 1'b0);
    chk("t4_bad_ch_err", 0, 64'(err_w[0]), 64'd1);
    chk("t4_bad_ch_data", 0, 64'(data_w[0]), 64'd0);
    cycle(5'd0, 5'd0, 1'b1, 0, 0, 3, 1'b0);
    chk("t4_bad_word_err", 1, 64'(err_w[1]), 64'd1);

    // Five slow triggers on ch0, then a live read
    repeat (5) cycle(5'b00001, 5'd0, 1'b0, 0, 0, 0, 1'b0);
    cycle(5'd0, 5'd0, 1'b1, 0, 0, 0, 1'b0);
    chk("t1_live_w0", 0, 64'(data_w[0]), 64'd5);
    chk("t1_ack", 0, 64'(ack_w[0]), 64'd1);

    // 4295 fast triggers on ch1 -> 4,295,000,000 = 0x1_0000_7FC0
    repeat (4295) cycle(5'b00010, 5'b00010, 1'b0, 0, 0, 0, 1'b0);
    cycle(5'd0, 5'd0, 1'b1, 1, 0, 0, 1'b1);
    chk("t2_atomic_w0", 0, 64'(data_w[0]), 64'h0000_7FC0);
    repeat (3) cycle(5'b00010, 5'b00010, 1'b0, 0, 0, 0, 1'b0);
    cycle(5'd0, 5'd0, 1'b1, 1, 1, 1, 1'b1);
    chk("t2_atomic_w1", 0, 64'(data_w[0]), 64'd1);
    cycle(5'd0, 5'd0, 1'b1, 1, 1, 1, 1'b0);
    chk("t2_live_w1", 0, 64'(data_w[0]), 64'd1);

    // Snapshot on ch2 does not authorise upper-word reads of ch3
    cycle(5'd0, 5'd0, 1'b1, 2, 0, 0, 1'b1);
    cycle(5'd0, 5'd0, 1'b1, 3, 1, 1, 1'b1);
    chk("t4_other_ch_err", 0, 64'(err_w[0]), 64'd1);
    cycle(5'd0, 5'd0, 1'b1, 2, 1, 1, 1'b1);

    // Same-edge trigger and capture on ch0 at count 9
    repeat (4) cycle(5'b00001, 5'd0, 1'b0, 0, 0, 0, 1'b0);
    cycle(5'b00001, 5'd0, 1'b1, 0, 0, 0, 1'b1);
    chk("t5_capture_data", 0, 64'(data_w[0]), 64'd9);
    cycle(5'd0, 5'd0, 1'b1, 0, 0, 0, 1'b0);
    chk("t5_live_after", 0, 64'(data_w[0]), 64'd10);
    cycle(5'd0, 5'd0, 1'b1, 0, 1, 1, 1'b1);

    // Drive ch3 of the 24-bit DUTs to all-ones, then overflow it
    repeat (4095) cycle(5'b01000, 5'b01000, 1'b0, 0, 0, 0, 1'b0);
    repeat (4095) cycle(5'b01000, 5'd0, 1'b0, 0, 0, 0, 1'b0);
    cycle(5'd0, 5'd0, 1'b1, 3, 0, 2, 1'b0);
    chk("t3_at_max_w2", 1, 64'(data_w[1]), 64'hFF);
    cycle(5'b01000, 5'd0, 1'b0, 0, 0, 0, 1'b0);
    chk("t3_wrap_ovf", 1, 64'(ovf_w[1][3]), 64'd1);
    chk("t3_sat_ovf", 2, 64'(ovf_w[2][3]), 64'd1);
    chk("t3_main_no_ovf", 0, 64'(ovf_w[0][3]), 64'd0);
    for (int w = 0; w < 3; w++) begin
      cycle(5'd0, 5'd0, 1'b1, 3, 0, w, 1'b0);
      chk("t3_wrap_zero", 1, 64'(data_w[1]), 64'd0);
      chk("t3_sat_hold", 2, 64'(data_w[2]), 64'hFF);
    end
    cycle(5'd0, 5'd0, 1'b1, 3, 0, 0, 1'b1);
    chk("t3_ovf_cleared", 1, 64'(ovf_w[1][3]), 64'd0);
    cycle(5'b01000, 5'b01000, 1'b0, 0, 0, 0, 1'b0);
    chk("t3_sat_reset_again", 2, 64'(ovf_w[2][3]), 64'd1);

    // Random traffic
    last_ch = 0;
    for (int i = 0; i < 1500; i++) begin
      rt  = 5'($urandom);
      rf  = 5'($urandom);
      rch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) :
            (($urandom_range(0, 1) == 0) ? last_ch : int'($urandom_range(0, 4)));
      last_ch = rch;
      cycle(rt, rf, 1'($urandom_range(0, 1)), rch, int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset between request and acknowledge
    trig_i = 5'd0; fast_i = 5'd0; req_i = 1'b1; ch_i = 3'd0;
    word_m = 1'b0; word_s = 2'd0; atomic_i = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    compare_all();
    chk("t6_no_ack", 0, 64'(ack_w[0]), 64'd0);
    req_i = 1'b0;
    #3 reset = 1'b1;
    cycle(5'd0, 5'd0, 1'b1, 0, 1, 1, 1'b1);
    chk("t6_atomic_w1_err", 0, 64'(err_w[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
